// File: rtl/data_cache_responder.sv
// data_cache_responder: 8-line x 16-byte direct-mapped, write-back, write-allocate data cache.
// Hit/miss performance counters are built only when DCACHE_PERF_CNT_EN is defined.
module data_cache_responder (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [1:0]   mem_byte_enable,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    output logic         mem_resp,
    output logic [15:0]  mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);
    localparam int unsigned LINES  = 8;
    localparam int unsigned LINE_W = 128;
    localparam int unsigned TAG_W  = 9;
    localparam int unsigned IDX_W  = 3;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] CHECK     = 3'd1;
    localparam logic [2:0] WRITEBACK = 3'd2;
    localparam logic [2:0] ALLOCATE  = 3'd3;
    localparam logic [2:0] DONE      = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [15:1]       addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [1:0]        be_q, be_d;
    logic              is_write_q, is_write_d;
    logic              mem_resp_q, mem_resp_d;
    logic [15:0]       mem_rdata_q, mem_rdata_d;
    logic              pmem_read_q, pmem_read_d;
    logic              pmem_write_q, pmem_write_d;
    logic [15:0]       pmem_address_q, pmem_address_d;
    logic [LINE_W-1:0] pmem_wdata_q, pmem_wdata_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic [LINES-1:0]  dirty_q, dirty_d;

    logic [LINE_W-1:0] data_q [LINES];
    logic [TAG_W-1:0]  tag_q  [LINES];

    logic [IDX_W-1:0]  idx_c;
    logic [TAG_W-1:0]  tag_c;
    logic [2:0]        word_c;
    logic [LINE_W-1:0] line_c;
    logic [LINE_W-1:0] line_wdata_c;
    logic [15:0]       word_old_c;
    logic [15:0]       word_new_c;
    logic              hit_c;
    logic              line_we_c;
    logic              tag_we_c;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = mem_address[0];

    // Lookup is driven from the address latched in IDLE, never the live request.
    assign idx_c      = addr_q[6:4];
    assign tag_c      = addr_q[15:7];
    assign word_c     = addr_q[3:1];
    assign line_c     = data_q[idx_c];
    assign word_old_c = line_c[{word_c, 4'b0000} +: 16];
    assign hit_c      = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
    assign word_new_c = {be_q[1] ? wdata_q[15:8] : word_old_c[15:8],
                         be_q[0] ? wdata_q[7:0]  : word_old_c[7:0]};

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        be_d           = be_q;
        is_write_d     = is_write_q;
        mem_rdata_d    = mem_rdata_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        line_we_c      = 1'b0;
        tag_we_c       = 1'b0;
        line_wdata_c   = line_c;

        case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    addr_d     = mem_address[15:1];
                    wdata_d    = mem_wdata;
                    be_d       = mem_byte_enable;
                    is_write_d = mem_write;
                    state_d    = CHECK;
                end
            end
            CHECK: begin
                if (hit_c) begin
                    state_d = DONE;
                    if (is_write_q) begin
                        line_we_c = 1'b1;
                        line_wdata_c[{word_c, 4'b0000} +: 16] = word_new_c;
                        if (be_q != 2'b00) dirty_d[idx_c] = 1'b1;
                    end else begin
                        mem_rdata_d = word_old_c;
                    end
                end else if (valid_q[idx_c] && dirty_q[idx_c]) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = ALLOCATE;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) state_d = ALLOCATE;
            end
            ALLOCATE: begin
                if (pmem_resp) begin
                    line_we_c      = 1'b1;
                    tag_we_c       = 1'b1;
                    line_wdata_c   = pmem_rdata;
                    valid_d[idx_c] = 1'b1;
                    dirty_d[idx_c] = 1'b0;
                    state_d        = CHECK;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Strobes follow the next state so they rise and fall on the transition edges.
        mem_resp_d   = (state_d == DONE);
        pmem_write_d = (state_d == WRITEBACK);
        pmem_read_d  = (state_d == ALLOCATE);
        if (state_d == WRITEBACK) begin
            pmem_address_d = {tag_q[idx_c], idx_c, 4'b0000};
            pmem_wdata_d   = line_c;
        end else if (state_d == ALLOCATE) begin
            pmem_address_d = {addr_q[15:4], 4'b0000};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            be_q           <= '0;
            is_write_q     <= 1'b0;
            mem_resp_q     <= 1'b0;
            mem_rdata_q    <= '0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            be_q           <= be_d;
            is_write_q     <= is_write_d;
            mem_resp_q     <= mem_resp_d;
            mem_rdata_q    <= mem_rdata_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
        end
    end

    // Line data and tags carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (line_we_c) data_q[idx_c] <= line_wdata_c;
        if (tag_we_c)  tag_q[idx_c]  <= tag_c;
    end

    assign mem_resp     = mem_resp_q;
    assign mem_rdata    = mem_rdata_q;
    assign pmem_read    = pmem_read_q;
    assign pmem_write   = pmem_write_q;
    assign pmem_address = pmem_address_q;
    assign pmem_wdata   = pmem_wdata_q;

`ifdef DCACHE_PERF_CNT_EN
    logic [15:0] hit_cnt_q, hit_cnt_d;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        from_idle_q, from_idle_d;

    // Only the CHECK entered straight from IDLE counts; the post-fill re-check does not.
    always_comb begin
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        from_idle_d = (state_q == IDLE);
        if (state_q == CHECK && from_idle_q) begin
            if (hit_c) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
            from_idle_q <= 1'b0;
        end else begin
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            from_idle_q <= from_idle_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = 16'h0000;
    assign miss_count = 16'h0000;
`endif

endmodule
